// File: rtl/lcd_pkg.sv
// lcd_pkg: ST7789 opcodes, scheduler state/grant types and the address-argument byte picker.
package lcd_pkg;
  localparam logic [7:0] OP_CASET = 8'h2A;
  localparam logic [7:0] OP_RASET = 8'h2B;
  localparam logic [7:0] OP_RAMWR = 8'h2C;
  localparam logic [7:0] OP_NOP = 8'h00;
  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD, ST_CASET, ST_CARG, ST_RASET, ST_RARG, ST_RAMWR, ST_PIX_HI, ST_PIX_LO, ST_DONE
  } state_e;
  typedef enum logic {GRANT_WIN, GRANT_CMD} grant_e;
  function automatic logic [7:0] arg_byte(logic [15:0] a, logic [15:0] b, logic [1:0] i);
    return i[1] ? (i[0] ? b[7:0] : b[15:8]) : (i[0] ? a[7:0] : a[15:8]);
  endfunction
endpackage

// File: rtl/lcd_byte_reg.sv
// lcd_byte_reg: 1-deep byte holding register towards the serializer, reloadable while draining.
module lcd_byte_reg (
  input  logic       clk_spi,
  input  logic       reset,
  input  logic       load,
  input  logic       dc,
  input  logic [7:0] data,
  output logic       can_load,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       out_dc,
  output logic [7:0] out_data
);
  assign can_load = !out_valid || out_ready;
  always_ff @(posedge clk_spi) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_dc <= 1'b1;
      out_data <= 8'h00;
    end else if (load) begin
      out_valid <= 1'b1;
      out_dc <= dc;
      out_data <= data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/lcd_window_ctrl.sv
// lcd_window_ctrl: schedules CASET/RASET/RAMWR window writes and RGB565 pixel bytes,
// sharing the serializer byte port with a fairly arbitrated raw command port.
module lcd_window_ctrl
  import lcd_pkg::*;
#(
  parameter int c_x_bits = 8,
  parameter int c_y_bits = 8,
  parameter int c_x_offset = 0,
  parameter int c_y_offset = 0,
  parameter logic [7:0] c_caset = OP_CASET,
  parameter logic [7:0] c_raset = OP_RASET,
  parameter logic [7:0] c_ramwr = OP_RAMWR
) (
  input  logic                clk_spi,
  input  logic                reset,
  input  logic                win_valid,
  output logic                win_ready,
  input  logic [c_x_bits-1:0] win_x0,
  input  logic [c_x_bits-1:0] win_x1,
  input  logic [c_y_bits-1:0] win_y0,
  input  logic [c_y_bits-1:0] win_y1,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [15:0]         pix_color,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dc,
  input  logic [7:0]          cmd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_dc,
  output logic [7:0]          out_data,
  output logic [c_x_bits-1:0] x,
  output logic [c_y_bits-1:0] y,
  output logic                busy,
  output logic                win_done,
  output logic                win_error
);
  localparam int c_cnt_bits = c_x_bits + c_y_bits + 1;
  state_e state, state_n;
  grant_e last_grant;
  logic [c_x_bits-1:0] bx0, bx1;
  logic [c_y_bits-1:0] by0, by1;
  logic cmd_dc_q;
  logic [7:0] cmd_data_q, pix_lo, ld_data;
  logic [1:0] arg_idx;
  logic [c_cnt_bits-1:0] cnt, w_cnt, h_cnt;
  logic [15:0] cx0, cx1, ry0, ry1;
  logic load, ld_dc, can_load, ok, grant_win, bad_win;
  lcd_byte_reg u_byte_reg (
    .clk_spi(clk_spi), .reset(reset), .load(load), .dc(ld_dc), .data(ld_data),
    .can_load(can_load), .out_ready(out_ready), .out_valid(out_valid),
    .out_dc(out_dc), .out_data(out_data)
  );
  assign ok = can_load && !reset;
  assign grant_win = win_valid && (!cmd_valid || last_grant == GRANT_CMD);
  assign bad_win = (win_x1 < win_x0) || (win_y1 < win_y0);
  assign cx0 = 16'(bx0) + 16'(c_x_offset);
  assign cx1 = 16'(bx1) + 16'(c_x_offset);
  assign ry0 = 16'(by0) + 16'(c_y_offset);
  assign ry1 = 16'(by1) + 16'(c_y_offset);
  assign w_cnt = c_cnt_bits'(bx1) - c_cnt_bits'(bx0) + c_cnt_bits'(1);
  assign h_cnt = c_cnt_bits'(by1) - c_cnt_bits'(by0) + c_cnt_bits'(1);
  assign busy = state != ST_IDLE || out_valid;
  always_comb begin
    state_n = state;
    load = 1'b0;
    ld_dc = 1'b1;
    ld_data = 8'h00;
    win_ready = 1'b0;
    cmd_ready = 1'b0;
    pix_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        win_ready = ok && grant_win;
        cmd_ready = ok && !grant_win && cmd_valid;
        state_n = win_ready ? (bad_win ? ST_IDLE : ST_CASET) : cmd_ready ? ST_CMD : ST_IDLE;
      end
      ST_CMD: begin
        load = can_load;
        ld_dc = cmd_dc_q;
        ld_data = cmd_data_q;
        state_n = can_load ? ST_IDLE : ST_CMD;
      end
      ST_CASET: begin
        load = can_load;
        ld_dc = 1'b0;
        ld_data = c_caset;
        state_n = can_load ? ST_CARG : ST_CASET;
      end
      ST_CARG: begin
        load = can_load;
        ld_data = arg_byte(cx0, cx1, arg_idx);
        state_n = (can_load && arg_idx == 2'd3) ? ST_RASET : ST_CARG;
      end
      ST_RASET: begin
        load = can_load;
        ld_dc = 1'b0;
        ld_data = c_raset;
        state_n = can_load ? ST_RARG : ST_RASET;
      end
      ST_RARG: begin
        load = can_load;
        ld_data = arg_byte(ry0, ry1, arg_idx);
        state_n = (can_load && arg_idx == 2'd3) ? ST_RAMWR : ST_RARG;
      end
      ST_RAMWR: begin
        load = can_load;
        ld_dc = 1'b0;
        ld_data = c_ramwr;
        state_n = can_load ? ST_PIX_HI : ST_RAMWR;
      end
      ST_PIX_HI: begin
        pix_ready = ok;
        load = ok && pix_valid;
        ld_data = pix_color[15:8];
        state_n = load ? ST_PIX_LO : ST_PIX_HI;
      end
      ST_PIX_LO: begin
        load = can_load;
        ld_data = pix_lo;
        state_n = can_load ? (cnt == c_cnt_bits'(1) ? ST_DONE : ST_PIX_HI) : ST_PIX_LO;
      end
      ST_DONE: state_n = (!out_valid || out_ready) ? ST_IDLE : ST_DONE;
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_spi) begin
    if (reset) begin
      state <= ST_IDLE;
      last_grant <= GRANT_CMD;
      bx0 <= '0;
      bx1 <= '0;
      by0 <= '0;
      by1 <= '0;
      cmd_dc_q <= 1'b1;
      cmd_data_q <= 8'h00;
      pix_lo <= 8'h00;
      arg_idx <= 2'd0;
      cnt <= '0;
      x <= '0;
      y <= '0;
      win_done <= 1'b0;
      win_error <= 1'b0;
    end else begin
      state <= state_n;
      win_done <= state == ST_DONE && state_n == ST_IDLE;
      win_error <= win_ready && bad_win;
      if (win_ready) begin
        bx0 <= win_x0;
        bx1 <= win_x1;
        by0 <= win_y0;
        by1 <= win_y1;
      end
      if (cmd_ready) begin
        cmd_dc_q <= cmd_dc;
        cmd_data_q <= cmd_data;
        last_grant <= GRANT_CMD;
      end
      // a dropped window also counts as a window turn so a bad requester cannot starve the raw port
      if ((win_ready && bad_win) || (state == ST_DONE && state_n == ST_IDLE))
        last_grant <= GRANT_WIN;
      if (load && (state == ST_CARG || state == ST_RARG))
        arg_idx <= arg_idx + 2'd1;
      if (load && state == ST_RAMWR) begin
        x <= bx0;
        y <= by0;
        cnt <= w_cnt * h_cnt;
      end
      if (load && state == ST_PIX_HI)
        pix_lo <= pix_color[7:0];
      if (load && state == ST_PIX_LO) begin
        x <= x == bx1 ? bx0 : x + c_x_bits'(1);
        y <= x == bx1 ? y + c_y_bits'(1) : y;
        cnt <= cnt - c_cnt_bits'(1);
      end
    end
  end
endmodule

// File: tb/tb_lcd_window_ctrl.sv
// tb_lcd_window_ctrl: scoreboard bench for the window scheduler; a second instance carries a column offset.
module tb_lcd_window_ctrl;
  import lcd_pkg::*;
  typedef struct {
    logic dc;
    logic [7:0] data;
    bit chk;
    logic [7:0] ex;
    logic [7:0] ey;
  } exp_t;
  typedef struct {
    logic [7:0] x0;
    logic [7:0] x1;
    logic [7:0] y0;
    logic [7:0] y1;
  } win_t;
  logic clk_spi, reset;
  logic win_valid, win_ready, pix_valid, pix_ready, cmd_valid, cmd_ready, cmd_dc;
  logic [7:0] win_x0, win_x1, win_y0, win_y1, cmd_data;
  logic [15:0] pix_color;
  logic out_valid, out_ready, out_dc, busy, win_done, win_error;
  logic [7:0] out_data, x, y;
  logic o1_win_ready, o1_pix_ready, o1_cmd_ready, o1_valid, o1_dc, o1_busy, o1_done, o1_error;
  logic [7:0] o1_data, o1_x, o1_y;
  exp_t exp_q[$];
  win_t win_q[$];
  logic [8:0] cmd_q[$];
  logic [15:0] pix_q[$];
  logic [7:0] cap1[$];
  int n_checks = 0, n_errors = 0, n_done = 0, n_werr = 0;
  bit toggle = 0, prev_stall = 0;
  logic [9:0] prev_word = '0;
  lcd_window_ctrl dut0 (
    .clk_spi(clk_spi), .reset(reset), .win_valid(win_valid), .win_ready(win_ready),
    .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_color(pix_color),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dc(cmd_dc), .cmd_data(cmd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_dc(out_dc), .out_data(out_data),
    .x(x), .y(y), .busy(busy), .win_done(win_done), .win_error(win_error)
  );
  lcd_window_ctrl #(.c_x_offset(80)) dut1 (
    .clk_spi(clk_spi), .reset(reset), .win_valid(win_valid), .win_ready(o1_win_ready),
    .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
    .pix_valid(pix_valid), .pix_ready(o1_pix_ready), .pix_color(pix_color),
    .cmd_valid(cmd_valid), .cmd_ready(o1_cmd_ready), .cmd_dc(cmd_dc), .cmd_data(cmd_data),
    .out_valid(o1_valid), .out_ready(out_ready), .out_dc(o1_dc), .out_data(o1_data),
    .x(o1_x), .y(o1_y), .busy(o1_busy), .win_done(o1_done), .win_error(o1_error)
  );
  initial clk_spi = 1'b0;
  always #5 clk_spi = ~clk_spi;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic pb(logic dc, logic [7:0] d, bit chk = 0, logic [7:0] ex = 0, logic [7:0] ey = 0);
    exp_t e;
    e.dc = dc; e.data = d; e.chk = chk; e.ex = ex; e.ey = ey;
    exp_q.push_back(e);
  endtask
  task automatic push_window(logic [7:0] x0, x1, y0, y1, logic [15:0] c0, c1);
    win_t w;
    int k = 0;
    logic [15:0] c;
    w.x0 = x0; w.x1 = x1; w.y0 = y0; w.y1 = y1;
    win_q.push_back(w);
    pb(0, 8'h2A); pb(1, 8'h00); pb(1, x0); pb(1, 8'h00); pb(1, x1);
    pb(0, 8'h2B); pb(1, 8'h00); pb(1, y0); pb(1, 8'h00); pb(1, y1);
    pb(0, 8'h2C);
    for (int yy = int'(y0); yy <= int'(y1); yy++)
      for (int xx = int'(x0); xx <= int'(x1); xx++) begin
        c = (k == 0) ? c0 : c1 + 16'((k - 1) * 257);
        pix_q.push_back(c);
        pb(1, c[15:8], 1, 8'(xx), 8'(yy));
        pb(1, c[7:0]);
        k++;
      end
  endtask
  // one cycle: observe and score at negedge, then advance the requester queues after the edge
  task automatic tick();
    bit wf, cf, pf;
    exp_t e;
    @(negedge clk_spi);
    if (prev_stall) check("stall_hold", {out_valid, out_dc, out_data}, prev_word);
    prev_stall = out_valid && !out_ready;
    prev_word = {out_valid, out_dc, out_data};
    if (win_done) n_done++;
    if (win_error) n_werr++;
    if (o1_valid && out_ready) cap1.push_back(o1_data);
    if (out_valid && out_ready) begin
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_errors++;
        $error("FAIL extra_byte: observed %0h expected none", out_data);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("byte", {out_dc, out_data}, {e.dc, e.data});
        if (e.chk) check("pix_xy", {x, y}, {e.ex, e.ey});
      end
    end
    wf = win_valid && win_ready;
    cf = cmd_valid && cmd_ready;
    pf = pix_valid && pix_ready;
    @(posedge clk_spi);
    #1;
    if (wf) win_q.delete(0);
    if (cf) cmd_q.delete(0);
    if (pf) pix_q.delete(0);
    win_valid = win_q.size() > 0;
    if (win_valid) {win_x0, win_x1, win_y0, win_y1} = {win_q[0].x0, win_q[0].x1, win_q[0].y0, win_q[0].y1};
    cmd_valid = cmd_q.size() > 0;
    if (cmd_valid) {cmd_dc, cmd_data} = cmd_q[0];
    pix_valid = pix_q.size() > 0;
    pix_color = pix_valid ? pix_q[0] : 16'h0000;
    out_ready = toggle ? !out_ready : 1'b1;
  endtask
  task automatic drain(string tag, int max);
    int i = 0;
    while (i < max && !(exp_q.size() == 0 && win_q.size() == 0 && cmd_q.size() == 0 && !busy)) begin
      tick();
      i++;
    end
    check(tag, 32'(i < max), 1);
    tick();
    tick();
  endtask
  initial begin
    int i, e0, d0;
    win_t w;
    reset = 1'b1;
    {win_valid, pix_valid, cmd_valid, cmd_dc} = '0;
    {win_x0, win_x1, win_y0, win_y1, cmd_data, pix_color} = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out", {out_valid, out_dc, out_data}, {1'b0, 1'b1, 8'h00});
    check("rst_ready", {win_ready, pix_ready, cmd_ready}, 0);
    check("rst_xy", {x, y}, 0);
    check("rst_flags", {busy, win_done, win_error}, 0);
    check("rst_state", dut0.state, ST_IDLE);
    reset = 1'b0;
    push_window(8'd0, 8'd1, 8'd0, 8'd0, 16'hF800, 16'h07E0);
    cmd_q.push_back({1'b0, 8'h36});
    pb(0, 8'h36);
    push_window(8'd2, 8'd2, 8'd3, 8'd3, 16'h1234, 16'h0000);
    cmd_q.push_back({1'b1, 8'h55});
    pb(1, 8'h55);
    drain("arb_drain", 400);
    check("arb_done", n_done, 2);
    cap1.delete();
    push_window(8'd10, 8'd239, 8'd5, 8'd5, 16'hA5A5, 16'h0001);
    drain("off_drain", 2000);
    check("off_carg", {cap1[1], cap1[2], cap1[3], cap1[4]}, 32'h005A013F);
    check("off_done", n_done, 3);
    toggle = 1;
    push_window(8'd0, 8'd1, 8'd0, 8'd1, 16'h1111, 16'h2222);
    drain("tog_drain", 400);
    toggle = 0;
    tick();
    check("tog_done", n_done, 4);
    e0 = n_werr;
    w.x0 = 8'd5; w.x1 = 8'd3; w.y0 = 8'd0; w.y1 = 8'd0;
    win_q.push_back(w);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("err_ov", out_valid, 0);
      check("err_busy", busy, 0);
    end
    check("err_pulse", n_werr, e0 + 1);
    check("err_q", win_q.size(), 0);
    d0 = n_done;
    push_window(8'd0, 8'd3, 8'd0, 8'd3, 16'hC000, 16'h0100);
    i = 0;
    while (pix_q.size() > 13 && i < 500) begin
      tick();
      i++;
    end
    check("mid_wait", 32'(i < 500), 1);
    reset = 1'b1;
    tick();
    check("mid_ov", out_valid, 0);
    check("mid_state", dut0.state, ST_IDLE);
    check("mid_xy", {x, y}, 0);
    exp_q.delete();
    pix_q.delete();
    win_q.delete();
    reset = 1'b0;
    tick();
    push_window(8'd1, 8'd1, 8'd1, 8'd1, 16'hBEEF, 16'h0000);
    drain("fresh_drain", 400);
    check("fresh_done", n_done, d0 + 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/lcd_window_ctrl.md
Name: lcd_window_ctrl

Overview:
- Byte-level scheduler in front of the SPI LCD serializer (ST7789-class panel).
- Accepts rectangular window-write requests and sequences CASET / RASET / RAMWR with their arguments, then streams RGB565 pixels as byte pairs.
- Shares the single serializer byte port with a raw command/data port used by the soft-CPU. Window traffic has priority, with alternation so the raw port is never starved.

Parameters:
- c_x_bits, 8, width of x coordinates
- c_y_bits, 8, width of y coordinates
- c_x_offset, 0, added to x0/x1 before CASET (panel RAM offset, e.g. 80 for 240x240 on 240x320 RAM)
- c_y_offset, 0, added to y0/y1 before RASET
- c_caset, 8'h2A, column address set opcode
- c_raset, 8'h2B, row address set opcode
- c_ramwr, 8'h2C, memory write opcode

Ports:
- clk_spi  in  1  single clock
- reset  in  1  synchronous, active-high
- win_valid  in  1  window request valid
- win_ready  out  1  window request accepted when valid&ready
- win_x0, win_x1  in  c_x_bits  inclusive column bounds
- win_y0, win_y1  in  c_y_bits  inclusive row bounds
- pix_valid  in  1  pixel available
- pix_ready  out  1  pixel consumed when valid&ready
- pix_color  in  16  RGB565 pixel
- cmd_valid  in  1  raw byte request
- cmd_ready  out  1  raw byte accepted
- cmd_dc  in  1  0 = command, 1 = data
- cmd_data  in  8  raw byte
- out_valid  out  1  byte to serializer valid
- out_ready  in  1  serializer accepts byte
- out_dc  out  1  D/C line value for out_data
- out_data  out  8  byte to serialize
- x  out  c_x_bits  column of pixel currently emitted
- y  out  c_y_bits  row of pixel currently emitted
- busy  out  1  state != IDLE or out_valid
- win_done  out  1  one-cycle pulse after last pixel byte handshaked
- win_error  out  1  one-cycle pulse when an illegal window is dropped

Behaviour:
- Reset values:
  - out_valid = 0, out_dc = 1, out_data = 0
  - win_ready = pix_ready = cmd_ready = 0
  - x = 0, y = 0, busy = 0, win_done = 0, win_error = 0
  - state = IDLE, last_grant = CMD
- Reset mid-window aborts immediately. No further bytes are emitted; the partially written RAM window is not repaired.
- Output register:
  - Byte transfer occurs on out_valid & out_ready.
  - out_data and out_dc are stable while out_valid & !out_ready.
  - A new byte may load in the same cycle a transfer completes, giving full throughput of 1 byte/clk.
- States: IDLE, CMD, CASET, CARG, RASET, RARG, RAMWR, PIX_HI, PIX_LO, DONE.
- IDLE arbitration:
  - If both win_valid and cmd_valid are set, grant the requester opposite last_grant. Otherwise grant whichever is valid.
  - win_ready / cmd_ready are asserted combinationally in IDLE for the granted requester, only when the output register can load.
- Window granted:
  - Latch the bounds.
  - If win_x1 < win_x0 or win_y1 < win_y0: pulse win_error, return to IDLE, emit nothing.
  - Otherwise go to CASET.
- CMD: one byte is loaded with dc = cmd_dc, then return to IDLE. Each raw byte is arbitrated individually.
- CASET emits c_caset with dc = 0.
- CARG emits 4 bytes with dc = 1: (x0+c_x_offset)[15:8], [7:0], then (x1+c_x_offset)[15:8], [7:0]. The sum is computed zero-extended to 16 bits.
- RASET / RARG: same scheme with y and c_y_offset.
- RAMWR emits c_ramwr with dc = 0. Then x = x0, y = y0, and the pixel counter is loaded with (x1-x0+1)*(y1-y0+1).
- PIX_HI:
  - pix_ready is high when the output register can load.
  - On pixel handshake, emit pix_color[15:8] with dc = 1 and hold pix_color[7:0].
  - Pixel accepted in cycle N gives the high byte valid in cycle N+1.
- PIX_LO:
  - Emit the held low byte.
  - On load, advance x; at x1, wrap x to x0 and increment y.
  - Decrement the counter. If the counter reaches 0, go to DONE; else go to PIX_HI.
- While pix_valid is low, no bytes are emitted and out_valid drops once the current byte drains. The serializer stops its clock.
- DONE: wait for the last byte handshake, pulse win_done, set last_grant = WIN, return to IDLE.
- Raw commands are never interleaved inside a window.
- Single-pixel window (x0 = x1, y0 = y1): exactly 11 header bytes plus 2 pixel bytes.

Decomposition:
- Package lcd_pkg holds:
  - ST7789 opcodes: CASET, RASET, RAMWR, NOP
  - state enum
  - grant enum {GRANT_WIN, GRANT_CMD}
- Natural sub-module: lcd_byte_reg, the 1-deep output holding register with valid/ready and load-while-drain. It is reused by the init sequencer.

Test Plan:
- Window (0,0)-(1,0), no offsets, out_ready = 1, pixels 16'hF800 and 16'h07E0 -> bytes 2A, 00 00 00 01, 2B, 00 00 00 00, 2C, F8 00 07 E0. dc = 0 on the three opcodes, 1 elsewhere. Then win_done pulses once.
- c_x_offset = 80, window x 10..239 -> CARG bytes 00 5A 01 3F.
- win_valid and cmd_valid both held high after reset (last_grant = CMD) -> full window first, then exactly one cmd byte, then the next window.
- out_ready toggling 1-0-1-0 during pixels -> no byte lost or duplicated; out_data stable while stalled; x/y sequence (0,0)(1,0)(0,1)(1,1) for a 2x2 window.
- Window with x1 = 3, x0 = 5 -> win_error pulse, out_valid never asserted, busy returns low next cycle.
- reset asserted during the third pixel of a 4x4 window -> next cycle out_valid = 0, state IDLE, x = y = 0. A following window sends a full, fresh header.
